muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative HI/LO multiply/divide unit in the execute stage, alongside the ALU.
- Takes the same R-type Funct field and operands that feed ALU control/ALU.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and handles MTHI/MTLO writes.
- Holds architectural HI/LO for MFHI/MFLO and asserts Busy so the hazard unit stalls the pipeline.

Parameters:
MUL_BITS_PER_CYCLE, 1, multiplier bits retired per iteration; legal values 1, 2, 4; multiply iterations = 32/MUL_BITS_PER_CYCLE.
DIV_ZERO_LO, 32'hFFFF_FFFF, LO result on divide by zero.

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
Start  input  1  execute-stage R-type instruction valid this cycle
Funct  input  6  instruction funct field
A  input  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
B  input  32  rt operand (divisor / multiplier)
Flush  input  1  synchronous abort of an in-flight operation
Busy  output  1  operation in flight; stall any HI/LO-touching instruction
Done  output  1  one-cycle pulse on the cycle HI/LO take a mul/div result
Hi  output  32  HI register
Lo  output  32  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; Busy=0, Done=0, Hi=0, Lo=0; all internal registers cleared.
- Funct decode applies only when Start=1 and state=IDLE:
  - 0x18 MULT
  - 0x19 MULTU
  - 0x1A DIV
  - 0x1B DIVU
  - 0x11 MTHI: Hi<=A next edge
  - 0x13 MTLO: Lo<=A next edge
  - any other Funct: ignored
- MTHI/MTLO: single cycle; no Busy, no Done.
- States: IDLE -> MUL or DIV -> FIX -> IDLE.
- IDLE + Start + mul/div Funct:
  - latch |A| and |B| (signed ops) or raw A and B (unsigned ops);
  - latch the result sign flags;
  - load iteration counter;
  - Busy=1 from the next cycle.
- MUL: shift-add over a 64-bit product, MUL_BITS_PER_CYCLE multiplier bits per cycle; 32/MUL_BITS_PER_CYCLE cycles.
- DIV: restoring division, one quotient bit per cycle; 32 cycles.
- FIX: one cycle.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Write Hi/Lo; Done=1 on this cycle; Busy deasserts on the following cycle.
- Latency (Start edge to Hi/Lo update):
  - MUL: 32/MUL_BITS_PER_CYCLE + 1 cycles (33 at default).
  - DIV: 33 cycles.
  - Busy is high for exactly that many cycles.
- Results:
  - MULT/MULTU: {Hi,Lo} = 64-bit product.
  - DIV/DIVU: Lo = quotient, Hi = remainder.
- Divide by zero: normal latency; Lo=DIV_ZERO_LO, Hi=A (original dividend, signed and unsigned).
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: Lo=0x8000_0000, Hi=0.
- Start while Busy: ignored; the hazard unit guarantees a stall, and the unit does not queue.
- Flush:
  - Any state -> IDLE next edge; Hi/Lo unchanged; Busy=0 next cycle; no Done.
  - Flush and Start in the same cycle: Flush wins, Start is dropped.
  - Flush on the FIX cycle: Hi/Lo not written.
- Reset mid-operation: immediate return to IDLE with Hi=Lo=0.
- Hi/Lo hold their value while Busy; MFHI/MFLO are stalled externally, not blocked here.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MULT/MULTU use a single-cycle 64-bit multiply.
  - Operands are latched in IDLE; the product is computed in a one-cycle MUL state, then FIX.
  - Latency 2 cycles, Busy high 2 cycles; MUL_BITS_PER_CYCLE ignored.
- Undefined: iterative shift-add as above.
- Divide behaviour is identical in both builds.

Test Plan:
- Reset: rst_n=0 mid-DIV -> Busy=0, Done=0, Hi=Lo=0 immediately; Start MTLO A=0x1234 after release -> Lo=0x0000_1234 next edge, Busy stays 0.
- MULT A=0xFFFF_FFFE (-2), B=0x0000_0003 -> after 33 cycles Hi=0xFFFF_FFFF, Lo=0xFFFF_FFFA, Done one pulse; MULTU same operands -> Hi=0x0000_0002, Lo=0xFFFF_FFFA.
- DIV A=0xFFFF_FFF9 (-7), B=2 -> Lo=0xFFFF_FFFD, Hi=0xFFFF_FFFF after 33 cycles; DIVU A=100, B=7 -> Lo=14, Hi=2.
- DIVU A=0x0000_0055, B=0 -> Lo=0xFFFF_FFFF, Hi=0x0000_0055; DIV 0x8000_0000 / 0xFFFF_FFFF -> Lo=0x8000_0000, Hi=0.
- Flush at cycle 10 of MULT after Hi/Lo preloaded 0xAAAA_AAAA/0x5555_5555 -> Busy low next cycle, no Done, Hi/Lo unchanged; Start MULTU on cycle 5 of a busy DIV -> ignored, DIV result correct.
- MULDIV_FAST_MUL_EN defined: MULTU 0xFFFF_FFFF × 0xFFFF_FFFF -> Busy 2 cycles, Hi=0xFFFF_FFFE, Lo=0x0000_0001; MUL_BITS_PER_CYCLE=4 iterative build -> same result after 9 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU over multiple cycles, MTHI/MTLO in one.
// Optional build macro MULDIV_FAST_MUL_EN selects a single-cycle 64-bit multiply instead of shift-add.
module muldiv_unit #(
  parameter int          MUL_BITS_PER_CYCLE = 1,
  parameter logic [31:0] DIV_ZERO_LO        = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [5:0]  Funct,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam int NB = MUL_BITS_PER_CYCLE;
  localparam int MW = 32 + NB;
`ifdef MULDIV_FAST_MUL_EN
  localparam logic [5:0] MUL_LAST = 6'd0;
`else
  localparam logic [5:0] MUL_LAST = 6'(32 / NB - 1);
`endif

  state_t      state, state_nx;
  logic [63:0] acc;        // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] a_reg, b_reg;
  logic [5:0]  cnt;
  logic        neg_lo, neg_hi, div_op, div_zero;

  logic        is_mul, is_div, accept, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] mul_next, div_next, prod;
  logic [31:0] fix_hi, fix_lo;

  assign is_mul = (Funct == F_MULT) || (Funct == F_MULTU);
  assign is_div = (Funct == F_DIV)  || (Funct == F_DIVU);
  assign accept = Start && (state == IDLE) && !Flush;
  assign a_neg  = !Funct[0] && A[31];
  assign b_neg  = !Funct[0] && B[31];
  assign a_mag  = a_neg ? -A : A;
  assign b_mag  = b_neg ? -B : B;

  assign Busy = (state != IDLE);
  assign Done = (state == FIX) && !Flush;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && is_mul) state_nx = MUL;
            else if (accept && is_div) state_nx = DIV;
      MUL, DIV: if (cnt == 6'd0) state_nx = FIX;
      FIX: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (Flush) state_nx = IDLE;
  end

`ifdef MULDIV_FAST_MUL_EN
  assign mul_next = {32'b0, a_reg} * {32'b0, b_reg};
`else
  logic [MW-1:0]   mul_sum;
  logic [63+NB:0]  mul_wide;
  // NOTE: always_comb uses blocking '=' so each loop pass sees the previous partial sum.
  always_comb begin
    mul_sum = MW'(acc[63:32]);
    for (int i = 0; i < NB; i++)
      if (acc[i]) mul_sum = mul_sum + (MW'(a_reg) << i);
    mul_wide = {mul_sum, acc[31:0]};
  end
  assign mul_next = mul_wide[63+NB:NB];
`endif

  // Restoring step: the 33-bit trial keeps the bit shifted out of the remainder.
  logic [64:0] div_shift;
  logic [32:0] div_trial;
  assign div_shift = {acc, 1'b0};
  assign div_trial = div_shift[64:32] - {1'b0, b_reg};
  assign div_next  = div_trial[32] ? div_shift[63:0]
                                   : {div_trial[31:0], div_shift[31:1], 1'b1};

  always_comb begin
    prod = neg_lo ? -acc : acc;
    if (div_op) begin
      fix_hi = div_zero ? a_reg : (neg_hi ? -acc[63:32] : acc[63:32]);
      fix_lo = div_zero ? DIV_ZERO_LO : (neg_lo ? -acc[31:0] : acc[31:0]);
    end else begin
      fix_hi = prod[63:32];
      fix_lo = prod[31:0];
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: the datapath is a handful of flops, not a RAM, so every register is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      cnt      <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_op   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept && (is_mul || is_div)) begin
          // Divide keeps the raw dividend in a_reg for the divide-by-zero HI result.
          a_reg    <= is_div ? A : a_mag;
          b_reg    <= b_mag;
          acc      <= {32'b0, is_div ? a_mag : b_mag};
          cnt      <= is_div ? 6'd31 : MUL_LAST;
          neg_lo   <= a_neg ^ b_neg;
          neg_hi   <= a_neg;
          div_op   <= is_div;
          div_zero <= is_div && (B == 32'b0);
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt - 6'd1;
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt - 6'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Hi <= '0;
      Lo <= '0;
    end else if (state == FIX && !Flush) begin
      Hi <= fix_hi;
      Lo <= fix_lo;
    end else if (accept && Funct == F_MTHI) begin
      Hi <= A;
    end else if (accept && Funct == F_MTLO) begin
      Lo <= A;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table plus flush, stall and reset sequences.
module tb_muldiv_unit;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

`ifdef MULDIV_FAST_MUL_EN
  localparam int M_LAT  = 2;
  localparam int M4_LAT = 2;
`else
  localparam int M_LAT  = 33;
  localparam int M4_LAT = 9;
`endif
  localparam int D_LAT = 33;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  logic        clk, rst_n, Start, Flush;
  logic [5:0]  Funct;
  logic [31:0] A, B;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;
  logic        start4, busy4, done4;
  logic [31:0] hi4, lo4;

  int checks   = 0;
  int failures = 0;

  muldiv_unit u_dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Funct(Funct), .A(A), .B(B),
    .Flush(Flush), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  muldiv_unit #(.MUL_BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .Start(start4), .Funct(Funct), .A(A), .B(B),
    .Flush(Flush), .Busy(busy4), .Done(done4), .Hi(hi4), .Lo(lo4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Single-cycle instruction (MTHI/MTLO/ignored funct); leaves time at negedge+1.
  task automatic mt(input logic [5:0] f, input logic [31:0] a);
    @(negedge clk);
    Start = 1'b1; Funct = f; A = a; B = 32'h0;
    @(negedge clk);
    Start = 1'b0;
    #1;
  endtask

  // Issue one op, then watch Busy/Done each cycle; optional Flush and stray Start injection.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int inject_at,
                        output int busy_cycles, output int done_cnt, output int last_done);
    @(negedge clk);
    Start = 1'b1; Funct = f; A = a; B = b; Flush = 1'b0;
    busy_cycles = 0; done_cnt = 0; last_done = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      Start = (i == inject_at);
      if (i == inject_at) begin
        Funct = F_MULTU; A = 32'h3; B = 32'h3;
      end
      Flush = (i == flush_at);
      #1;
      if (!Busy) break;
      busy_cycles = i;
      if (Done) begin
        done_cnt++;
        last_done = i;
      end
    end
    Start = 1'b0;
    Flush = 1'b0;
  endtask

  vec_t vecs[11];
  int   bc, dc, ld;

  initial begin
    vecs[0]  = '{F_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, M_LAT};
    vecs[1]  = '{F_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, M_LAT};
    vecs[2]  = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, D_LAT};
    vecs[3]  = '{F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        D_LAT};
    vecs[4]  = '{F_DIVU,  32'h0000_0055, 32'h0,         32'h0000_0055, 32'hFFFF_FFFF, D_LAT};
    vecs[5]  = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, D_LAT};
    vecs[6]  = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, M_LAT};
    vecs[7]  = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, D_LAT};
    vecs[8]  = '{F_DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, D_LAT};
    vecs[9]  = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         M_LAT};
    vecs[10] = '{F_MULT,  32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, M_LAT};

    rst_n = 1'b0; Start = 1'b0; start4 = 1'b0; Flush = 1'b0;
    Funct = 6'h0; A = 32'h0; B = 32'h0;
    #1;
    check("reset_busy", Busy, 1'b0);
    check("reset_done", Done, 1'b0);
    check("reset_hi",   Hi,   32'h0);
    check("reset_lo",   Lo,   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      run_op(vecs[v].f, vecs[v].a, vecs[v].b, 0, 0, bc, dc, ld);
      check($sformatf("vec%0d_busy_cycles", v), bc, vecs[v].lat);
      check($sformatf("vec%0d_done_count", v), dc, 1);
      check($sformatf("vec%0d_done_cycle", v), ld, vecs[v].lat);
      check($sformatf("vec%0d_hi", v), Hi, vecs[v].hi);
      check($sformatf("vec%0d_lo", v), Lo, vecs[v].lo);
    end

    // MTHI/MTLO are single-cycle with no Busy; an unrelated funct is ignored.
    mt(F_MTHI, 32'hAAAA_AAAA);
    check("mthi_hi", Hi, 32'hAAAA_AAAA);
    check("mthi_busy", Busy, 1'b0);
    mt(F_MTLO, 32'h5555_5555);
    check("mtlo_lo", Lo, 32'h5555_5555);
    check("mtlo_hi_kept", Hi, 32'hAAAA_AAAA);
    mt(6'h20, 32'h1111_1111);
    check("other_funct_hi", Hi, 32'hAAAA_AAAA);
    check("other_funct_lo", Lo, 32'h5555_5555);
    check("other_funct_busy", Busy, 1'b0);

    // Flush on cycle 10 of MULT.
    run_op(F_MULT, 32'h5, 32'h7, 10, 0, bc, dc, ld);
    check("flush_mid_busy_cycles", bc, 10);
    check("flush_mid_done", dc, 0);
    check("flush_mid_hi", Hi, 32'hAAAA_AAAA);
    check("flush_mid_lo", Lo, 32'h5555_5555);

    // Flush on the FIX cycle suppresses the write and Done.
    run_op(F_MULTU, 32'h2, 32'h3, M_LAT, 0, bc, dc, ld);
    check("flush_fix_busy_cycles", bc, M_LAT);
    check("flush_fix_done", dc, 0);
    check("flush_fix_hi", Hi, 32'hAAAA_AAAA);
    check("flush_fix_lo", Lo, 32'h5555_5555);

    // Flush and Start together: Start dropped.
    @(negedge clk);
    Start = 1'b1; Funct = F_DIVU; A = 32'd9; B = 32'd2; Flush = 1'b1;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    #1;
    check("flush_start_busy", Busy, 1'b0);

    // Stray MULTU on cycle 5 of a busy DIVU is ignored.
    run_op(F_DIVU, 32'd100, 32'd7, 0, 5, bc, dc, ld);
    check("inject_busy_cycles", bc, D_LAT);
    check("inject_done", dc, 1);
    check("inject_hi", Hi, 32'd2);
    check("inject_lo", Lo, 32'd14);

    // Reset in the middle of a DIV.
    @(negedge clk);
    Start = 1'b1; Funct = F_DIV; A = 32'd50; B = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("pre_reset_busy", Busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_busy", Busy, 1'b0);
    check("mid_reset_done", Done, 1'b0);
    check("mid_reset_hi", Hi, 32'h0);
    check("mid_reset_lo", Lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mt(F_MTLO, 32'h0000_1234);
    check("post_reset_mtlo", Lo, 32'h0000_1234);
    check("post_reset_busy", Busy, 1'b0);

    // Four multiplier bits per cycle.
    @(negedge clk);
    start4 = 1'b1; Funct = F_MULTU; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    bc = 0; dc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start4 = 1'b0;
      #1;
      if (!busy4) break;
      bc = i;
      if (done4) dc++;
    end
    check("bits4_busy_cycles", bc, M4_LAT);
    check("bits4_done", dc, 1);
    check("bits4_hi", hi4, 32'hFFFF_FFFE);
    check("bits4_lo", lo4, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
